pe_array_drain: RTL and testbench
=================================

PE_ARRAY_DRAIN -- requirements
Module: pe_array_drain

Interface
REQ-001 SHALL have parameter W, default 8, operand width; result lanes are 2*W bits.
REQ-002 SHALL have parameter N, default 16, number of PE_array columns/lanes.
REQ-003 SHALL have parameter DEPTH, default 32, row FIFO depth; must be a power of two and at least N+1.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port c_in  input  [N-1:0][2*W-1:0]  skewed partial-sum lanes from the PE_array c_out.
REQ-007 SHALL have port c_in_valid  input  1  marks the cycle in which lane 0 of a result row is present.
REQ-008 SHALL have port flush  input  1  synchronous clear of the pipeline and FIFO.
REQ-009 SHALL have port row_data  output  [N-1:0][2*W-1:0]  realigned result row at the FIFO head.
REQ-010 SHALL have port row_valid  output  1  row_data holds a valid row.
REQ-011 SHALL have port row_ready  input  1  consumer accepts the row when row_valid and row_ready are both high.
REQ-012 SHALL have port space_ok  output  1  upstream may launch another row.
REQ-013 SHALL have port overflow  output  1  sticky flag; a row was dropped.
REQ-014 SHALL have port row_count  output  16  rows written into the FIFO, modulo 2^16.

Function
REQ-015 Skew model: lane j of row k SHALL be sampled exactly j cycles after the c_in_valid cycle of row k.
REQ-016 Lane j SHALL be delayed by N-1-j register stages; lane N-1 passes with zero delay; c_in_valid SHALL be delayed by N-1 stages.
REQ-017 Aligned row: when c_in_valid is high in cycle t, the aligned row SHALL be complete in cycle t+N-1 and written to the FIFO at the end of that cycle.
REQ-018 Latency SHALL be N cycles from c_in_valid to row_valid when the FIFO is empty; there is no combinational bypass.
REQ-019 Back-to-back: c_in_valid SHALL be accepted in every cycle; rows overlapping in the skew window SHALL not corrupt each other.
REQ-020 Pop SHALL occur on a cycle with row_valid and row_ready both high; row_data and row_valid SHALL hold stable while row_valid is high and row_ready is low.
REQ-021 row_data SHALL be 0 whenever row_valid is 0.
REQ-022 Push when full SHALL be accepted only if a pop occurs in the same cycle; otherwise the row SHALL be dropped, overflow set, and row_count left unchanged.
REQ-023 Simultaneous push and pop with the FIFO empty: push stores the row, pop is not possible, and row_valid SHALL rise the next cycle.
REQ-024 space_ok SHALL be high iff the free entries, minus rows in flight in the skew pipeline, are at least 1.
REQ-025 row_count SHALL increment by 1 per accepted push and wrap from 0xFFFF to 0x0000.
REQ-026 flush SHALL, at the next edge, empty the FIFO and clear all in-flight valid bits; flush has priority over any push or pop in the same cycle.
REQ-027 flush SHALL clear overflow; flush SHALL NOT clear row_count.
REQ-028 overflow SHALL stay set until rst or flush.
REQ-029 Read and write pointers SHALL carry one extra wrap bit for full/empty detection.

Reset
REQ-030 On rst high, all delay-stage valid bits, FIFO pointers, row_count and overflow SHALL clear immediately, without waiting for clk.
REQ-031 During and after reset, outputs SHALL read row_valid=0, row_data=0, space_ok=1, overflow=0, row_count=0.
REQ-032 A reset asserted mid-operation SHALL discard all in-flight and buffered rows; no partial row SHALL appear after deassertion.
REQ-033 Lane data stages need not be reset; only valid bits gate output.

Verification
REQ-034 Single row: N=16, c_in_valid at cycle 0, lane j = 0x0100+j at cycle j -> row_valid at cycle 16, row_data[j] = 0x0100+j for all j, row_count=1.
REQ-035 Streaming: 16 consecutive rows with row k lane j = k*16+j and row_ready=1 -> 16 rows out in order, rows on consecutive cycles, no overflow.
REQ-036 Backpressure: row_ready=0, rows launched while space_ok=1 -> launches stop with no overflow; then row_ready=1 -> all stored rows drain intact.
REQ-037 Overflow: row_ready=0, 33 rows forced regardless of space_ok, DEPTH=32 -> overflow=1, 32 rows stored, row_count=32; flush -> overflow=0, row_valid=0.
REQ-038 Async reset: rst asserted between clock edges with 5 rows in flight -> outputs reach reset values before the next edge; no rows emerge after release.
REQ-039 Flush race: flush in the same cycle as an aligned push and a pop -> FIFO empty next cycle, row_count unchanged.

Source files
------------

// File: rtl/pe_array_drain.sv
// Drain stage behind a systolic PE array: de-skews the diagonal partial-sum lanes
// into whole rows and buffers them in a row FIFO with a valid/ready consumer port.
module pe_array_drain #(
    parameter int W     = 8,
    parameter int N     = 16,
    parameter int DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0][2*W-1:0] c_in,
    input  logic                  c_in_valid,
    input  logic                  flush,
    output logic [N-1:0][2*W-1:0] row_data,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic                  space_ok,
    output logic                  overflow,
    output logic [15:0]           row_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 2;

    logic [N-1:0][2*W-1:0] aligned;
    logic [N-2:0]          vld_p;
    logic [N-2:0]          vld_next;
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           used;
    logic [SW-1:0]         free;
    logic [SW-1:0]         in_flight;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  accept;

    logic [N-1:0][2*W-1:0] mem [DEPTH];

    // Skew stages: lane j arrives j cycles late, so it waits N-1-j more cycles.
    genvar j;
    for (j = 0; j < N - 1; j++) begin : g_skew
        logic [2*W-1:0] lane_p [N-1-j];

        always_ff @(posedge clk) begin
            lane_p[0] <= c_in[j];
            for (int i = 1; i < N - 1 - j; i++) begin
                lane_p[i] <= lane_p[i-1];
            end
        end

        assign aligned[j] = lane_p[N-2-j];
    end
    assign aligned[N-1] = c_in[N-1];

    always_comb begin
        vld_next    = vld_p << 1;
        vld_next[0] = c_in_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p <= '0;
        end else if (flush) begin
            vld_p <= '0;
        end else begin
            vld_p <= vld_next;
        end
    end

    // Row FIFO: the top valid bit marks the cycle a fully aligned row is present.
    assign used   = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (used == (AW+1)'(DEPTH));
    assign push   = vld_p[N-2];
    assign pop    = !empty && row_ready;
    assign accept = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            mem[wr_ptr[AW-1:0]] <= aligned;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            row_count <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (accept) begin
                wr_ptr    <= wr_ptr + (AW+1)'(1);
                row_count <= row_count + 16'd1;
            end else if (push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Rows still in the skew pipeline already own a FIFO slot for flow control.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < N - 1; i++) begin
            in_flight = in_flight + SW'(vld_p[i]);
        end
    end

    assign free      = SW'(DEPTH) - SW'(used);
    assign space_ok  = (free > in_flight);
    assign row_valid = !empty;
    assign row_data  = row_valid ? mem[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_pe_array_drain.sv
// Bench for pe_array_drain: a queue-based row model is checked every cycle,
// with a vector table for single rows and directed multi-cycle sequences.
module tb_pe_array_drain;
    localparam int W     = 8;
    localparam int N     = 16;
    localparam int DEPTH = 32;

    typedef logic [N-1:0][2*W-1:0] row_t;
    typedef struct {
        int   t;
        row_t r;
    } flight_t;
    typedef struct {
        logic [15:0] base;
        int          hold;
        logic [15:0] exp_count;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    row_t        c_in;
    logic        c_in_valid;
    logic        flush;
    row_t        row_data;
    logic        row_valid;
    logic        row_ready;
    logic        space_ok;
    logic        overflow;
    logic [15:0] row_count;

    always #5 clk = ~clk;

    pe_array_drain #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .c_in       (c_in),
        .c_in_valid (c_in_valid),
        .flush      (flush),
        .row_data   (row_data),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .space_ok   (space_ok),
        .overflow   (overflow),
        .row_count  (row_count)
    );

    // Reference model: stored rows, rows launched but not yet aligned, flags.
    row_t        q[$];
    flight_t     fl[$];
    bit          m_ovf = 1'b0;
    logic [15:0] m_cnt = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    bit   g_launch = 1'b0;
    row_t g_row    = '0;
    bit   g_ready  = 1'b0;
    bit   g_flush  = 1'b0;

    int seen = 0;
    int prev_t = -1;
    int gaps = 0;

    task automatic chk(string name, logic [N*2*W-1:0] act, logic [N*2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_space_ok();
        return (DEPTH - q.size() - fl.size()) >= 1;
    endfunction

    function automatic row_t rnd_row();
        row_t r;
        for (int j = 0; j < N; j++) r[j] = (2*W)'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        fl.delete();
        m_ovf = 1'b0;
        m_cnt = '0;
    endtask

    task automatic check_model();
        row_t ev_row;
        bit   ev;
        ev     = (q.size() > 0);
        ev_row = ev ? q[0] : '0;
        chk("row_valid", row_valid, ev);
        chk("row_data", row_data, ev_row);
        chk("space_ok", space_ok, model_space_ok());
        chk("overflow", overflow, m_ovf);
        chk("row_count", row_count, m_cnt);
    endtask

    // Lane j in cycle c carries lane j of the row launched in cycle c-j, if any.
    task automatic drive();
        if (g_launch) fl.push_back('{cyc, g_row});
        c_in_valid = g_launch;
        flush      = g_flush;
        row_ready  = g_ready;
        for (int j = 0; j < N; j++) begin
            c_in[j] = (2*W)'($urandom);
            foreach (fl[i]) if (fl[i].t == cyc - j) c_in[j] = fl[i].r[j];
        end
    endtask

    task automatic model_update();
        bit popping;
        int idx;
        if (rst) begin
            model_reset();
        end else if (g_flush) begin
            q.delete();
            fl.delete();
            m_ovf = 1'b0;
        end else begin
            popping = g_ready && (q.size() > 0);
            if (popping) void'(q.pop_front());
            idx = -1;
            foreach (fl[i]) if (fl[i].t == cyc - (N - 1)) idx = i;
            if (idx >= 0) begin
                if (q.size() < DEPTH) begin
                    q.push_back(fl[idx].r);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
                fl.delete(idx);
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        drive();
        model_update();
        @(posedge clk);
    endtask

    task automatic reset_dut();
        g_launch = 1'b0;
        g_flush  = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        tick();
        #1 rst = 1'b0;
    endtask

    task automatic collect();
        row_t er;
        if (row_valid) begin
            for (int j = 0; j < N; j++) er[j] = (2*W)'(seen * 16 + j);
            chk("stream_row", row_data, er);
            if (prev_t >= 0 && cyc != prev_t + 1) gaps++;
            prev_t = cyc;
            seen++;
        end
    endtask

    task automatic chk_reset_values(string tag);
        chk({tag, "_valid"}, row_valid, 1'b0);
        chk({tag, "_data"}, row_data, '0);
        chk({tag, "_space"}, space_ok, 1'b1);
        chk({tag, "_ovf"}, overflow, 1'b0);
        chk({tag, "_count"}, row_count, 16'd0);
    endtask

    initial begin
        vec_t vecs[5];
        row_t er;
        int   launches;
        int   drained;
        int   after;

        vecs[0] = '{16'h0100, 0, 16'd1};
        vecs[1] = '{16'h0000, 2, 16'd2};
        vecs[2] = '{16'hFFF0, 1, 16'd3};
        vecs[3] = '{16'h8000, 3, 16'd4};
        vecs[4] = '{16'h1234, 0, 16'd5};

        rst        = 1'b0;
        c_in       = '0;
        c_in_valid = 1'b0;
        flush      = 1'b0;
        row_ready  = 1'b0;

        #2 rst = 1'b1;
        #1 chk_reset_values("por");
        tick();
        tick();
        #1 rst = 1'b0;

        // Single rows from the vector table: latency, lane contents, hold, pop.
        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < N; j++) er[j] = vecs[v].base + 16'(j);
            g_row    = er;
            g_launch = 1'b1;
            g_ready  = 1'b1;
            tick();
            g_launch = 1'b0;
            repeat (N - 2) tick();
            #1 chk("lat_early", row_valid, 1'b0);
            tick();
            #1;
            chk("lat_valid", row_valid, 1'b1);
            chk("row_lanes", row_data, er);
            chk("vec_count", row_count, vecs[v].exp_count);
            g_ready = 1'b0;
            for (int h = 0; h < vecs[v].hold; h++) begin
                tick();
                #1;
                chk("hold_valid", row_valid, 1'b1);
                chk("hold_data", row_data, er);
            end
            g_ready = 1'b1;
            tick();
            #1;
            chk("popped_valid", row_valid, 1'b0);
            chk("popped_data", row_data, '0);
        end

        // Streaming: 16 back-to-back rows out on consecutive cycles.
        seen = 0; prev_t = -1; gaps = 0;
        g_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < N; j++) g_row[j] = (2*W)'(k * 16 + j);
            g_launch = 1'b1;
            tick();
            #1 collect();
        end
        g_launch = 1'b0;
        repeat (N + 4) begin
            tick();
            #1 collect();
        end
        chk("stream_rows", seen, 16);
        chk("stream_gaps", gaps, 0);
        chk("stream_ovf", overflow, 1'b0);

        // Backpressure: launch only while space is advertised, then drain.
        reset_dut();
        g_ready  = 1'b0;
        launches = 0;
        for (int i = 0; i < 60; i++) begin
            g_launch = model_space_ok();
            if (g_launch) begin
                launches++;
                g_row = rnd_row();
            end
            tick();
        end
        g_launch = 1'b0;
        #1;
        chk("bp_launches", launches, DEPTH);
        chk("bp_ovf", overflow, 1'b0);
        chk("bp_count", row_count, 16'(DEPTH));
        chk("bp_space", space_ok, 1'b0);
        g_ready = 1'b1;
        drained = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (row_valid) drained++;
            tick();
            #1;
        end
        chk("bp_drained", drained, DEPTH);

        // Overflow: 33 forced rows into a 32-deep FIFO, then flush.
        reset_dut();
        g_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            g_launch = 1'b1;
            g_row    = rnd_row();
            tick();
        end
        g_launch = 1'b0;
        repeat (N) tick();
        #1;
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", row_count, 16'(DEPTH));
        chk("ovf_valid", row_valid, 1'b1);
        g_flush = 1'b1;
        tick();
        g_flush = 1'b0;
        #1;
        chk("flush_ovf", overflow, 1'b0);
        chk("flush_valid", row_valid, 1'b0);
        chk("flush_count", row_count, 16'(DEPTH));
        tick();

        // Flush racing an aligned push and a pop.
        reset_dut();
        g_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            g_launch = 1'b1;
            g_row    = rnd_row();
            tick();
        end
        g_launch = 1'b0;
        repeat (N - 2) tick();
        #1;
        chk("race_pre_valid", row_valid, 1'b1);
        chk("race_pre_count", row_count, 16'd2);
        g_flush = 1'b1;
        g_ready = 1'b1;
        tick();
        g_flush = 1'b0;
        #1;
        chk("race_empty", row_valid, 1'b0);
        chk("race_count", row_count, 16'd2);
        repeat (N) tick();

        // Asynchronous reset between edges with rows stored and in flight.
        g_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            g_launch = 1'b1;
            g_row    = rnd_row();
            tick();
        end
        g_launch = 1'b0;
        repeat (N) tick();
        for (int i = 0; i < 5; i++) begin
            g_launch = 1'b1;
            g_row    = rnd_row();
            tick();
        end
        g_launch = 1'b0;
        @(negedge clk);
        check_model();
        drive();
        #2 rst = 1'b1;
        #1 chk_reset_values("arst");
        model_update();
        @(posedge clk);
        tick();
        #1 rst = 1'b0;
        g_ready = 1'b1;
        after = 0;
        repeat (N + 6) begin
            tick();
            #1 if (row_valid) after++;
        end
        chk("arst_no_rows", after, 0);

        // Randomized traffic against the model, alternating drain pressure.
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            g_launch = ($urandom_range(0, 3) != 0) &&
                       (model_space_ok() || ($urandom_range(0, 5) == 0));
            g_row    = rnd_row();
            g_ready  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) != 0)
                                            : ($urandom_range(0, 9) < 2);
            g_flush  = ($urandom_range(0, 149) == 0);
            tick();
        end
        g_launch = 1'b0;
        g_flush  = 1'b0;
        g_ready  = 1'b1;
        repeat (N + DEPTH + 4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
